// File: rtl/dmem_dual_arbiter.sv
// Serialises the two memory-stage slots onto one SRAM-like data bus, slot0 first.
// Optional bus watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_dual_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                cpu_clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                s0_req_i,
    input  logic [DATA_W/8-1:0] s0_we_i,
    input  logic [DATA_W/8-1:0] s0_dre_i,
    input  logic [ADDR_W-1:0]   s0_addr_i,
    input  logic [DATA_W-1:0]   s0_wdata_i,
    input  logic                s1_req_i,
    input  logic [DATA_W/8-1:0] s1_we_i,
    input  logic [DATA_W/8-1:0] s1_dre_i,
    input  logic [ADDR_W-1:0]   s1_addr_i,
    input  logic [DATA_W-1:0]   s1_wdata_i,
    output logic                mem_req_o,
    output logic                mem_wr_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_addr_ok_i,
    input  logic                mem_data_ok_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                s0_done_o,
    output logic                s1_done_o,
    output logic [DATA_W-1:0]   s0_rdata_o,
    output logic [DATA_W-1:0]   s1_rdata_o,
    output logic                stall_o,
    output logic                bus_err_o
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    cur_q, cur_d;
    logic [1:0]              pend_q, pend_d;
    logic [1:0]              done_q, done_d;
    logic                    flush_q, flush_d;
    logic [1:0]              rd_we;
    logic [1:0][BE_W-1:0]    we_q, dre_q;
    logic [1:0][ADDR_W-1:0]  addr_q;
    logic [1:0][DATA_W-1:0]  wdata_q, rdata_q;
    logic                    capture, hold_off, timeout_hit;
    logic [1:0]              cand_pend, cand_null;

    // New requests are only sampled with nothing pending and no completion/error pulse showing.
    assign capture   = (state_q == S_IDLE) && (pend_q == 2'b00) && (s0_req_i | s1_req_i)
                       && !flush_i && !hold_off;
    assign cand_pend = capture ? {s1_req_i, s0_req_i} : pend_q;
    assign cand_null[0] = capture ? ~|(s0_we_i | s0_dre_i) : ~|(we_q[0] | dre_q[0]);
    assign cand_null[1] = capture ? ~|(s1_we_i | s1_dre_i) : ~|(we_q[1] | dre_q[1]);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        done_d  = 2'b00;
        flush_d = flush_q;
        rd_we   = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (flush_i) begin
                    pend_d = 2'b00;
                end else if (cand_pend[0]) begin
                    if (cand_null[0]) begin
                        done_d[0] = 1'b1;
                        pend_d    = {cand_pend[1], 1'b0};
                    end else begin
                        state_d = S_ADDR;
                        cur_d   = 1'b0;
                        pend_d  = cand_pend;
                    end
                end else if (cand_pend[1]) begin
                    if (cand_null[1]) begin
                        done_d[1] = 1'b1;
                        pend_d    = 2'b00;
                    end else begin
                        state_d = S_ADDR;
                        cur_d   = 1'b1;
                        pend_d  = cand_pend;
                    end
                end
            end
            S_ADDR: begin
                if (flush_i) flush_d = 1'b1;
                if (mem_addr_ok_i) begin
                    state_d = S_DATA;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    pend_d  = 2'b00;
                    flush_d = 1'b0;
                end
            end
            S_DATA: begin
                if (flush_i) flush_d = 1'b1;
                if (mem_data_ok_i) begin
                    state_d = S_IDLE;
                    if (flush_q || flush_i) begin
                        pend_d  = 2'b00;
                        flush_d = 1'b0;
                    end else begin
                        done_d[cur_q] = 1'b1;
                        rd_we[cur_q]  = 1'b1;
                        pend_d[cur_q] = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    pend_d  = 2'b00;
                    flush_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= 1'b0;
            pend_q  <= 2'b00;
            done_q  <= 2'b00;
            flush_q <= 1'b0;
            we_q    <= '0;
            dre_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            flush_q <= flush_d;
            if (capture) begin
                we_q[0]    <= s0_we_i;
                dre_q[0]   <= s0_dre_i;
                addr_q[0]  <= s0_addr_i;
                wdata_q[0] <= s0_wdata_i;
                we_q[1]    <= s1_we_i;
                dre_q[1]   <= s1_dre_i;
                addr_q[1]  <= s1_addr_i;
                wdata_q[1] <= s1_wdata_i;
            end
            if (rd_we[0]) rdata_q[0] <= mem_rdata_i;
            if (rd_we[1]) rdata_q[1] <= mem_rdata_i;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;
    logic       tmo_fire;

    assign timeout_hit = (state_q != S_IDLE) && (cnt_q == 8'(TIMEOUT - 1));
    assign tmo_fire    = timeout_hit && !((state_q == S_ADDR) && mem_addr_ok_i)
                         && !((state_q == S_DATA) && mem_data_ok_i);

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_d != state_q || state_q == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
            err_q <= tmo_fire;
        end
    end

    assign hold_off  = (|done_q) | err_q;
    assign bus_err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign hold_off    = |done_q;
    assign bus_err_o   = 1'b0;
`endif

    assign mem_req_o   = (state_q == S_ADDR);
    assign mem_wr_o    = mem_req_o & (|we_q[cur_q]);
    assign mem_wstrb_o = !mem_req_o ? '0 : ((|we_q[cur_q]) ? we_q[cur_q] : dre_q[cur_q]);
    assign mem_addr_o  = mem_req_o ? addr_q[cur_q] : '0;
    assign mem_wdata_o = mem_req_o ? wdata_q[cur_q] : '0;

    assign s0_done_o  = done_q[0];
    assign s1_done_o  = done_q[1];
    assign s0_rdata_o = rdata_q[0];
    assign s1_rdata_o = rdata_q[1];
    // Pending slots keep the pipeline held between the two accesses of a pair.
    assign stall_o = (state_q != S_IDLE) | (|pend_q) |
                     ((state_q == S_IDLE) & (s0_req_i | s1_req_i) & !flush_i & !hold_off);
endmodule

// File: tb/tb_dmem_dual_arbiter.sv
// Self-checking bench for dmem_dual_arbiter: vector table, bus responder and scoreboards.
module tb_dmem_dual_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef DMEM_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic cpu_clk = 1'b0;
  logic rst = 1'b1;
  logic flush_i = 1'b0;
  logic s0_req_i = 1'b0, s1_req_i = 1'b0;
  logic [3:0] s0_we_i = '0, s0_dre_i = '0, s1_we_i = '0, s1_dre_i = '0;
  logic [AW-1:0] s0_addr_i = '0, s1_addr_i = '0;
  logic [DW-1:0] s0_wdata_i = '0, s1_wdata_i = '0;
  logic mem_req_o, mem_wr_o;
  logic [3:0] mem_wstrb_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic mem_addr_ok_i = 1'b0, mem_data_ok_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic s0_done_o, s1_done_o, stall_o, bus_err_o;
  logic [DW-1:0] s0_rdata_o, s1_rdata_o;

  dmem_dual_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .cpu_clk(cpu_clk), .rst(rst), .flush_i(flush_i),
    .s0_req_i(s0_req_i), .s0_we_i(s0_we_i), .s0_dre_i(s0_dre_i),
    .s0_addr_i(s0_addr_i), .s0_wdata_i(s0_wdata_i),
    .s1_req_i(s1_req_i), .s1_we_i(s1_we_i), .s1_dre_i(s1_dre_i),
    .s1_addr_i(s1_addr_i), .s1_wdata_i(s1_wdata_i),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_addr_ok_i(mem_addr_ok_i), .mem_data_ok_i(mem_data_ok_i), .mem_rdata_i(mem_rdata_i),
    .s0_done_o(s0_done_o), .s1_done_o(s1_done_o),
    .s0_rdata_o(s0_rdata_o), .s1_rdata_o(s1_rdata_o),
    .stall_o(stall_o), .bus_err_o(bus_err_o)
  );

  // clock / reset
  always #5 cpu_clk = ~cpu_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboards: {wr, wstrb, addr, wdata} and {slot, is_load, rdata}
  logic [68:0] exp_txn_q[$];
  logic [33:0] exp_done_q[$];

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a == 32'h8000_0010) return 32'h1234_5678;
    return {~a[15:0], a[15:0]};
  endfunction

  // bus responder: addr_ok after addr_wait cycles of mem_req, data_ok the cycle after
  int addr_wait = 0;
  int a_cnt = 0;
  bit d_pend = 0;
  bit req_wait_prev = 0;
  bit tmo_mode = 0;
  logic [31:0] d_val = '0;
  logic [31:0] hold_addr = '0;

  always @(negedge cpu_clk) begin
    if (rst) begin
      mem_addr_ok_i = 1'b0;
      mem_data_ok_i = 1'b0;
      d_pend = 0;
      a_cnt = 0;
      req_wait_prev = 0;
    end else begin
      mem_addr_ok_i = 1'b0;
      mem_data_ok_i = 1'b0;
      if (d_pend) begin
        mem_data_ok_i = 1'b1;
        mem_rdata_i = d_val;
        d_pend = 0;
      end
      if (req_wait_prev && !tmo_mode) check("req_held", mem_req_o, 1'b1);
      req_wait_prev = 0;
      if (mem_req_o) begin
        if (a_cnt == 0) hold_addr = mem_addr_o;
        else check("addr_stable", mem_addr_o, hold_addr);
        if (a_cnt >= addr_wait) begin
          mem_addr_ok_i = 1'b1;
          a_cnt = 0;
          if (exp_txn_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_txn: got addr %0h expected no access", mem_addr_o);
          end else begin
            check("bus_txn", {mem_wr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o}, exp_txn_q.pop_front());
          end
          d_pend = 1;
          d_val = mem_wr_o ? 32'h0 : model_rdata(mem_addr_o);
        end else begin
          a_cnt++;
          req_wait_prev = 1;
        end
      end else begin
        a_cnt = 0;
      end
    end
  end

  task automatic handle_done(input logic slot, input logic [31:0] rd);
    logic [33:0] e;
    if (exp_done_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_done: got slot %0d done expected none", slot);
    end else begin
      e = exp_done_q.pop_front();
      check("done_slot", slot, e[33]);
      if (e[32]) check("done_rdata", rd, e[31:0]);
    end
  endtask

  int err_pulses = 0;
  always @(negedge cpu_clk) begin
    if (!rst) begin
      if (s0_done_o) handle_done(1'b0, s0_rdata_o);
      if (s1_done_o) handle_done(1'b1, s1_rdata_o);
      if (bus_err_o) err_pulses++;
    end
  end

  typedef struct {
    logic r0; logic [3:0] we0; logic [3:0] dre0; logic [31:0] a0; logic [31:0] w0;
    logic r1; logic [3:0] we1; logic [3:0] dre1; logic [31:0] a1; logic [31:0] w1;
    int aw; int d0; int d1; int fin;
  } vec_t;

  vec_t vecs[11];

  task automatic push_slot(input logic r, input logic [3:0] we, input logic [3:0] dre,
                           input logic [31:0] a, input logic [31:0] w, input logic slot);
    if (!r) return;
    if (we == 4'h0 && dre == 4'h0) begin
      exp_done_q.push_back({slot, 1'b0, 32'h0});
    end else begin
      exp_txn_q.push_back({(|we), ((|we) ? we : dre), a, w});
      exp_done_q.push_back({slot, (we == 4'h0), model_rdata(a)});
    end
  endtask

  // driver: hold the pair until stall drops, recording done-pulse cycles
  task automatic apply(input vec_t v, input string tag);
    int c0 = -1;
    int c1 = -1;
    int fin = -1;
    addr_wait = v.aw;
    push_slot(v.r0, v.we0, v.dre0, v.a0, v.w0, 1'b0);
    push_slot(v.r1, v.we1, v.dre1, v.a1, v.w1, 1'b1);
    @(negedge cpu_clk);
    s0_req_i = v.r0; s0_we_i = v.we0; s0_dre_i = v.dre0; s0_addr_i = v.a0; s0_wdata_i = v.w0;
    s1_req_i = v.r1; s1_we_i = v.we1; s1_dre_i = v.dre1; s1_addr_i = v.a1; s1_wdata_i = v.w1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (s0_done_o) c0 = cyc;
      if (s1_done_o) c1 = cyc;
      if (!stall_o) begin
        fin = cyc;
        break;
      end
      @(negedge cpu_clk);
    end
    @(negedge cpu_clk);
    s0_req_i = 1'b0;
    s1_req_i = 1'b0;
    @(negedge cpu_clk);
    addr_wait = 0;
    check({tag, "_s0_done_cyc"}, c0, v.d0);
    check({tag, "_s1_done_cyc"}, c1, v.d1);
    check({tag, "_stall_end_cyc"}, fin, v.fin);
  endtask

  task automatic flush_seq(input int aw, input int fcyc, input int exp_fin, input string tag);
    int fin = -1;
    addr_wait = aw;
    exp_txn_q.push_back({1'b0, 4'hF, 32'h8000_0100, 32'h0});
    @(negedge cpu_clk);
    s0_req_i = 1'b1; s0_we_i = 4'h0; s0_dre_i = 4'hF; s0_addr_i = 32'h8000_0100; s0_wdata_i = 32'h0;
    s1_req_i = 1'b1; s1_we_i = 4'h0; s1_dre_i = 4'hF; s1_addr_i = 32'h8000_0200; s1_wdata_i = 32'h0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (cyc == fcyc) begin
        flush_i = 1'b1;
        s0_req_i = 1'b0;
        s1_req_i = 1'b0;
      end
      if (cyc == fcyc + 1) flush_i = 1'b0;
      #1;
      if (!stall_o && cyc > fcyc) begin
        fin = cyc;
        break;
      end
      @(negedge cpu_clk);
    end
    flush_i = 1'b0;
    repeat (6) @(negedge cpu_clk);
    addr_wait = 0;
    check({tag, "_stall_end_cyc"}, fin, exp_fin);
    check({tag, "_txn_left"}, exp_txn_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{1, 4'h0, 4'hF, 32'h8000_0010, 32'h0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 0, 3, -1, 3};
    vecs[1] = '{1, 4'hF, 4'h0, 32'h8000_0000, 32'hAABB_CCDD,
                1, 4'h0, 4'h8, 32'h8000_0003, 32'h0, 0, 3, 6, 6};
    vecs[2] = '{0, 4'h0, 4'h0, 32'h0, 32'h0, 1, 4'hC, 4'h0, 32'h1FAF_F002, 32'hBEEF_0000, 0, -1, 3, 3};
    vecs[3] = '{1, 4'h0, 4'hF, 32'h8000_0040, 32'h0, 1, 4'h0, 4'h3, 32'h8000_0044, 32'h0, 0, 3, 6, 6};
    vecs[4] = '{1, 4'h0, 4'h0, 32'h8000_0051, 32'h0, 1, 4'h0, 4'hF, 32'h8000_0060, 32'h0, 0, 1, 4, 4};
    vecs[5] = '{1, 4'h0, 4'hF, 32'h8000_0070, 32'h0, 1, 4'h0, 4'h0, 32'h8000_0073, 32'h0, 0, 3, 4, 4};
    vecs[6] = '{1, 4'h0, 4'h0, 32'h8000_0081, 32'h0, 1, 4'h0, 4'h0, 32'h8000_0082, 32'h0, 0, 1, 2, 2};
    vecs[7] = '{1, 4'h0, 4'hF, 32'h8000_0090, 32'h0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 5, 8, -1, 8};
    for (int i = 8; i < 11; i++) begin
      vecs[i].r0 = 1; vecs[i].we0 = 4'h3 << (2 * $urandom_range(0, 1)); vecs[i].dre0 = 4'h0;
      vecs[i].a0 = $urandom & 32'hFFFF_FFFE; vecs[i].w0 = $urandom;
      vecs[i].r1 = 1; vecs[i].we1 = 4'h0; vecs[i].dre1 = 4'h1 << $urandom_range(0, 3);
      vecs[i].a1 = $urandom; vecs[i].w1 = $urandom;
      vecs[i].aw = 0; vecs[i].d0 = 3; vecs[i].d1 = 6; vecs[i].fin = 6;
    end

    repeat (3) @(negedge cpu_clk);
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_done", {s0_done_o, s1_done_o}, 2'b00);
    check("rst_rdata", {s0_rdata_o, s1_rdata_o}, 64'h0);
    check("rst_bus", {mem_wr_o, mem_wstrb_o, mem_addr_o, mem_wdata_o}, 69'h0);
    check("rst_bus_err", bus_err_o, 1'b0);

    for (int i = 0; i < 11; i++) apply(vecs[i], $sformatf("vec%0d", i));

    flush_seq(0, 2, 3, "flush_data");
    flush_seq(3, 2, 6, "flush_addr");

    // reset in the middle of an address phase
    addr_wait = 10;
    @(negedge cpu_clk);
    s0_req_i = 1'b1; s0_we_i = 4'h0; s0_dre_i = 4'hF; s0_addr_i = 32'h8000_0300;
    repeat (3) @(negedge cpu_clk);
    s0_req_i = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_mem_req", mem_req_o, 1'b0);
    check("midrst_stall", stall_o, 1'b0);
    @(negedge cpu_clk);
    rst = 1'b0;
    addr_wait = 0;
    repeat (2) @(negedge cpu_clk);

`ifdef DMEM_TIMEOUT_EN
    begin
      int ecyc = -1;
      int fin = -1;
      tmo_mode = 1;
      addr_wait = 1000;
      err_pulses = 0;
      @(negedge cpu_clk);
      s0_req_i = 1'b1; s0_we_i = 4'h0; s0_dre_i = 4'hF; s0_addr_i = 32'h8000_0400;
      for (int cyc = 0; cyc < 64; cyc++) begin
        #1;
        if (bus_err_o && ecyc < 0) ecyc = cyc;
        if (!stall_o) begin
          fin = cyc;
          break;
        end
        @(negedge cpu_clk);
      end
      @(negedge cpu_clk);
      s0_req_i = 1'b0;
      repeat (3) @(negedge cpu_clk);
      tmo_mode = 0;
      addr_wait = 0;
      check("tmo_err_cyc", ecyc, 17);
      check("tmo_stall_end_cyc", fin, 17);
      check("tmo_err_pulses", err_pulses, 1);
      check("tmo_mem_req", mem_req_o, 1'b0);
    end
`else
    check("no_bus_err", err_pulses, 0);
`endif

    repeat (4) @(negedge cpu_clk);
    check("txn_queue_empty", exp_txn_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
